// File: rtl/serdes_pkg.sv
// Shared definitions for the D x S serializer/deserializer pair.
package serdes_pkg;

  localparam int   UNDERRUN_CNT_W   = 16;
  localparam logic DEFAULT_IDLE_BIT = 1'b0;

  typedef enum logic {
    ST_IDLE,
    ST_SEND
  } tx_state_e;

  // Slot counter width; a single-slot word still needs a 1-bit counter.
  function automatic int cnt_width(input int s);
    return (s > 1) ? $clog2(s) : 1;
  endfunction

endpackage

// File: rtl/serializer_hold_buffer.sv
// Single-entry holding register between the parallel handshake and the slot shifter.
module serializer_hold_buffer #(
  parameter int W = 32
) (
  input  logic         high_speed_clock,
  input  logic         reset,
  input  logic [W-1:0] data_in,
  input  logic         push,
  input  logic         pop,
  output logic [W-1:0] hold_data,
  output logic         hold_valid
);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      hold_valid <= 1'b0;
    end else if (push) begin
      hold_valid <= 1'b1;
    end else if (pop) begin
      hold_valid <= 1'b0;
    end
  end

  // NOTE: the payload register is not reset; hold_valid alone qualifies it.
  always_ff @(posedge high_speed_clock) begin
    if (push) begin
      hold_data <= data_in;
    end
  end

endmodule

// File: rtl/parallel_serializer.sv
// Streams a D*S-bit word as S D-bit slots, LSB slot first, with a one-word hold buffer.
// Optional: define PARALLEL_SERIALIZER_UNDERRUN_COUNT_EN to add a saturating underrun_count output.
module parallel_serializer
  import serdes_pkg::*;
#(
  parameter int             D            = 8,
  parameter int             S            = 4,
  parameter logic [D-1:0]   IDLE_PATTERN = {D{DEFAULT_IDLE_BIT}}
) (
  input  logic             high_speed_clock,
  input  logic             reset,
  input  logic [D*S-1:0]   data_in,
  input  logic             data_in_valid,
  output logic             data_in_ready,
  output logic [D-1:0]     data_out,
  output logic             data_out_valid,
  output logic             frame_start,
  output logic             underrun
`ifdef PARALLEL_SERIALIZER_UNDERRUN_COUNT_EN
  ,
  output logic [UNDERRUN_CNT_W-1:0] underrun_count
`endif
);

  localparam int             W    = D * S;
  localparam int             CW   = cnt_width(S);
  localparam logic [CW-1:0]  LAST = CW'(S - 1);

  tx_state_e     state, state_next;
  logic [W-1:0]  shreg, shreg_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [D-1:0]  data_out_next;
  logic          data_out_valid_next;
  logic          frame_start_next;
  logic          underrun_next;

  logic          boundary;
  logic          accept;
  logic          pop;
  logic [W-1:0]  hold_data;
  logic          hold_valid;

  // Ready depends only on registers, never on data_in_valid.
  assign boundary      = (state == ST_IDLE) || (cnt == LAST);
  assign data_in_ready = !hold_valid || boundary;
  assign accept        = data_in_valid && data_in_ready;
  assign pop           = boundary && hold_valid;

  serializer_hold_buffer #(
    .W (W)
  ) u_hold (
    .high_speed_clock (high_speed_clock),
    .reset            (reset),
    .data_in          (data_in),
    .push             (accept),
    .pop              (pop),
    .hold_data        (hold_data),
    .hold_valid       (hold_valid)
  );

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_next          = state;
    shreg_next          = shreg;
    cnt_next            = cnt;
    data_out_next       = data_out;
    data_out_valid_next = data_out_valid;
    frame_start_next    = 1'b0;
    underrun_next       = 1'b0;

    if (boundary) begin
      if (hold_valid) begin
        data_out_next       = hold_data[D-1:0];
        shreg_next          = hold_data >> D;
        cnt_next            = '0;
        state_next          = ST_SEND;
        data_out_valid_next = 1'b1;
        frame_start_next    = 1'b1;
      end else begin
        data_out_next       = IDLE_PATTERN;
        data_out_valid_next = 1'b0;
        state_next          = ST_IDLE;
        underrun_next       = (state == ST_SEND);
      end
    end else begin
      data_out_next = shreg[D-1:0];
      shreg_next    = shreg >> D;
      cnt_next      = cnt + 1'b1;
    end
  end

  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      state          <= ST_IDLE;
      cnt            <= '0;
      data_out       <= IDLE_PATTERN;
      data_out_valid <= 1'b0;
      frame_start    <= 1'b0;
      underrun       <= 1'b0;
    end else begin
      state          <= state_next;
      cnt            <= cnt_next;
      data_out       <= data_out_next;
      data_out_valid <= data_out_valid_next;
      frame_start    <= frame_start_next;
      underrun       <= underrun_next;
    end
  end

  // Shifter contents are meaningless while idle, so they carry no reset.
  always_ff @(posedge high_speed_clock) begin
    shreg <= shreg_next;
  end

`ifdef PARALLEL_SERIALIZER_UNDERRUN_COUNT_EN
  always_ff @(posedge high_speed_clock) begin
    if (reset) begin
      underrun_count <= '0;
    end else if (underrun_next && (underrun_count != '1)) begin
      underrun_count <= underrun_count + 1'b1;
    end
  end
`endif

endmodule
